// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core: load-use stalls,
// redirect flushes, data-memory wait freezes and HALT drain.
module hazard_stall_ctrl #(
  parameter int LOAD_STALL_CYC = 1,
  parameter int DRAIN_CYC      = 3,
  parameter int MEM_TIMEOUT    = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] ifid_rs1,
  input  logic [4:0] ifid_rs2,
  input  logic       ifid_uses_rs2,
  input  logic       id_halt,
  input  logic [4:0] idex_rd,
  input  logic       idex_memread,
  input  logic       ex_redirect,
  input  logic       exmem_memaccess,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_write,
  output logic       idex_flush,
  output logic       exmem_write,
  output logic       memwb_flush,
  output logic       mem_req,
  output logic       halted,
  output logic       mem_err
);

  typedef enum logic [2:0] {
    RUN, LU_STALL, MEM_WAIT, DRAIN, HALTED
  } state_t;

  state_t     state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic [7:0] tmo, tmo_nx;
  logic [2:0] drain, drain_nx;
  logic       err_nx;
  logic       lu_hit;
  logic       mem_miss;
  logic       draining;

  assign lu_hit = idex_memread && (idex_rd != 5'd0) &&
                  ((idex_rd == ifid_rs1) ||
                   (ifid_uses_rs2 && (idex_rd == ifid_rs2)));
  assign mem_miss = exmem_memaccess && !mem_ready;
  // A non-zero drain count marks a wait that interrupted DRAIN
  assign draining = (drain != 3'd0);

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_write = 1'b1;
    memwb_flush = 1'b0;
    mem_req     = 1'b0;
    halted      = 1'b0;
    state_nx    = state;
    cnt_nx      = cnt;
    tmo_nx      = tmo;
    drain_nx    = drain;
    err_nx      = mem_err;
    unique case (state)
      RUN: begin
        mem_req = exmem_memaccess;
        if (mem_miss) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_write = 1'b0;
          memwb_flush = 1'b1;
          tmo_nx      = 8'd1;
          state_nx    = MEM_WAIT;
        end else if (ex_redirect) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (id_halt) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          ifid_flush = 1'b1;
          drain_nx   = 3'd1;
          state_nx   = DRAIN;
        end else if (lu_hit) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          if (LOAD_STALL_CYC > 1) begin
            cnt_nx   = 3'd1;
            state_nx = LU_STALL;
          end
        end
      end
      LU_STALL: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
        mem_req    = exmem_memaccess;
        if (cnt == 3'(LOAD_STALL_CYC - 1)) begin
          cnt_nx   = 3'd0;
          state_nx = RUN;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      MEM_WAIT: begin
        mem_req = 1'b1;
        if (mem_ready || tmo == 8'(MEM_TIMEOUT)) begin
          if (!mem_ready) begin
            mem_req     = 1'b0;
            memwb_flush = 1'b1;
            err_nx      = 1'b1;
          end
          if (draining) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
          end
          tmo_nx   = 8'd0;
          state_nx = draining ? DRAIN : RUN;
        end else begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_write = 1'b0;
          memwb_flush = 1'b1;
          tmo_nx      = tmo + 8'd1;
        end
      end
      DRAIN: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b1;
        mem_req    = exmem_memaccess;
        if (mem_miss) begin
          idex_write  = 1'b0;
          exmem_write = 1'b0;
          memwb_flush = 1'b1;
          tmo_nx      = 8'd1;
          state_nx    = MEM_WAIT;
        end else if (drain == 3'(DRAIN_CYC)) begin
          state_nx = HALTED;
        end else begin
          drain_nx = drain + 3'd1;
        end
      end
      HALTED: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b1;
        idex_write  = 1'b0;
        idex_flush  = 1'b1;
        exmem_write = 1'b0;
        memwb_flush = 1'b1;
        halted      = 1'b1;
      end
      default: state_nx = RUN;
    endcase
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_write  = 1'b0;
      idex_flush  = 1'b1;
      exmem_write = 1'b0;
      memwb_flush = 1'b1;
      mem_req     = 1'b0;
      halted      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      cnt     <= 3'd0;
      tmo     <= 8'd0;
      drain   <= 3'd0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      tmo     <= tmo_nx;
      drain   <= drain_nx;
      mem_err <= err_nx;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: default and
// LOAD_STALL_CYC=2 instances share one input set.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic       ifid_uses_rs2, id_halt, idex_memread;
  logic       ex_redirect, exmem_memaccess, mem_ready;

  logic a_pw, a_iw, a_if, a_xw, a_xf, a_ew, a_mf, a_mr, a_h, a_e;
  logic b_pw, b_iw, b_if, b_xw, b_xf, b_ew, b_mf, b_mr, b_h, b_e;
  logic [9:0] oa, ob;

  int checks = 0;
  int errors = 0;

  // {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_f, req, halted, err}
  localparam logic [9:0] DEF  = 10'b1101010000;
  localparam logic [9:0] LU   = 10'b0001110000;
  localparam logic [9:0] RST  = 10'b0010101000;
  localparam logic [9:0] RDIR = 10'b1111110000;
  localparam logic [9:0] FRZ  = 10'b0000001100;
  localparam logic [9:0] REL  = 10'b1101010100;
  localparam logic [9:0] TMO  = 10'b1101011000;
  localparam logic [9:0] DRN  = 10'b0011010000;
  localparam logic [9:0] HLT  = 10'b0010101010;
  localparam logic [9:0] ERR  = 10'b0000000001;

  always #5 clk = ~clk;

  assign oa = {a_pw, a_iw, a_if, a_xw, a_xf, a_ew, a_mf, a_mr, a_h, a_e};
  assign ob = {b_pw, b_iw, b_if, b_xw, b_xf, b_ew, b_mf, b_mr, b_h, b_e};

  hazard_stall_ctrl dut_a (
    .clk(clk), .rst_n(rst_n),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_uses_rs2(ifid_uses_rs2), .id_halt(id_halt),
    .idex_rd(idex_rd), .idex_memread(idex_memread),
    .ex_redirect(ex_redirect),
    .exmem_memaccess(exmem_memaccess), .mem_ready(mem_ready),
    .pc_write(a_pw), .ifid_write(a_iw), .ifid_flush(a_if),
    .idex_write(a_xw), .idex_flush(a_xf), .exmem_write(a_ew),
    .memwb_flush(a_mf), .mem_req(a_mr), .halted(a_h),
    .mem_err(a_e)
  );

  hazard_stall_ctrl #(.LOAD_STALL_CYC(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_uses_rs2(ifid_uses_rs2), .id_halt(id_halt),
    .idex_rd(idex_rd), .idex_memread(idex_memread),
    .ex_redirect(ex_redirect),
    .exmem_memaccess(exmem_memaccess), .mem_ready(mem_ready),
    .pc_write(b_pw), .ifid_write(b_iw), .ifid_flush(b_if),
    .idex_write(b_xw), .idex_flush(b_xf), .exmem_write(b_ew),
    .memwb_flush(b_mf), .mem_req(b_mr), .halted(b_h),
    .mem_err(b_e)
  );

  task automatic chk(input string tag, input logic [9:0] got,
                     input logic [9:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic idle();
    ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; idex_rd = 5'd0;
    ifid_uses_rs2 = 1'b0; id_halt = 1'b0; idex_memread = 1'b0;
    ex_redirect = 1'b0; exmem_memaccess = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #1 chk("reset_a", oa, RST);
    chk("reset_b", ob, RST);

    nxt(); rst_n = 1'b1;
    #1 chk("run_default", oa, DEF);

    nxt(); idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs1 = 5'd5;
    ifid_rs2 = 5'd1;
    #1 chk("lu_rs1", oa, LU);
    nxt(); idle();
    #1 chk("lu_rs1_after", oa, DEF);

    nxt(); idex_memread = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0;
    #1 chk("lu_x0", oa, DEF);

    nxt(); idle(); idex_memread = 1'b1; idex_rd = 5'd7;
    ifid_rs1 = 5'd3; ifid_rs2 = 5'd7; ifid_uses_rs2 = 1'b1;
    #1 chk("lu2_rs2_c1", ob, LU);
    chk("lu1_rs2", oa, LU);
    nxt(); idle();
    #1 chk("lu2_rs2_c2", ob, LU);
    chk("lu1_rs2_after", oa, DEF);
    nxt();
    #1 chk("lu2_rs2_done", ob, DEF);

    nxt(); idex_memread = 1'b1; idex_rd = 5'd7;
    ifid_rs1 = 5'd3; ifid_rs2 = 5'd7; ifid_uses_rs2 = 1'b0;
    #1 chk("lu2_no_rs2", ob, DEF);
    nxt(); idle();
    #1 chk("lu2_no_rs2_next", ob, DEF);

    nxt(); ex_redirect = 1'b1; id_halt = 1'b1;
    idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs1 = 5'd5;
    #1 chk("redir_a", oa, RDIR);
    chk("redir_b", ob, RDIR);
    nxt(); idle();
    #1 chk("redir_after_a", oa, DEF);
    chk("redir_after_b", ob, DEF);

    nxt(); exmem_memaccess = 1'b1; mem_ready = 1'b0;
    #1 chk("wait_c1", oa, FRZ);
    for (int i = 2; i <= 4; i++) begin
      nxt();
      #1 chk($sformatf("wait_c%0d", i), oa, FRZ);
    end
    nxt(); mem_ready = 1'b1;
    #1 chk("wait_release", oa, REL);
    nxt(); idle();
    #1 chk("wait_after", oa, DEF);

    nxt(); mem_ready = 1'b1; exmem_memaccess = 1'b1;
    #1 chk("mem_single", oa, REL);

    nxt(); mem_ready = 1'b0;
    #1 chk("tmo_c0", oa, FRZ);
    for (int i = 1; i <= 14; i++) begin
      nxt();
      #1 chk($sformatf("tmo_c%0d", i), oa, FRZ);
    end
    nxt();
    #1 chk("tmo_hit", oa, TMO);
    nxt(); idle();
    #1 chk("tmo_err_sticky", oa, DEF | ERR);
    nxt();
    #1 chk("tmo_err_hold", oa, DEF | ERR);

    nxt(); id_halt = 1'b1;
    #1 chk("halt_decode", oa, DRN | ERR);
    nxt(); idle();
    for (int i = 1; i <= 3; i++) begin
      #1 chk($sformatf("drain_c%0d", i), oa, DRN | ERR);
      nxt();
    end
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("halted_%0d", i), oa, HLT | ERR);
      nxt();
    end

    #3 rst_n = 1'b0;
    #1 chk("reset_halted", oa, RST);
    nxt(); rst_n = 1'b1;
    #1 chk("after_reset_1", oa, DEF);

    nxt(); exmem_memaccess = 1'b1; mem_ready = 1'b0;
    #1 chk("rw_c1", oa, FRZ);
    nxt();
    #1 chk("rw_c2", oa, FRZ);
    #2 rst_n = 1'b0;
    #1 chk("reset_midwait", oa, RST);
    nxt(); idle();
    #1 chk("reset_hold", oa, RST);
    nxt(); rst_n = 1'b1;
    #1 chk("after_reset_2", oa, DEF);
    nxt();
    #1 chk("after_reset_3", oa, DEF);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencer for the 5-stage RV32I core. Sits beside the main decode controller.
- Drives PC and pipeline-register write enables, and the flushes that insert bubbles.
- Handles four conditions: load-use hazards, taken branches/jumps, multi-cycle data-memory handshakes, and HALT drain.
- Owns the only core-level state machine. All other control stays combinational.

Parameters:
- LOAD_STALL_CYC, 1, bubbles inserted per load-use hazard (1..3).
- DRAIN_CYC, 3, cycles after HALT decode before halted asserts (1..7).
- MEM_TIMEOUT, 15, max cycles waiting for mem_ready before mem_err (1..255).

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ifid_rs1  in  5  rs1 field of instruction in ID
- ifid_rs2  in  5  rs2 field of instruction in ID
- ifid_uses_rs2  in  1  ID instruction reads rs2 (R-type, SW, branch)
- id_halt  in  1  ID opcode is 7'b1111111
- idex_rd  in  5  rd of instruction in EX
- idex_memread  in  1  EX instruction is LW
- ex_redirect  in  1  EX resolved taken branch, JAL or JALR
- exmem_memaccess  in  1  MEM-stage instruction is LW or SW
- mem_ready  in  1  data memory completes access this cycle
- pc_write  out  1  PC register load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID cleared to NOP
- idex_write  out  1  ID/EX load enable
- idex_flush  out  1  ID/EX control bits cleared
- exmem_write  out  1  EX/MEM load enable
- memwb_flush  out  1  MEM/WB control bits cleared
- mem_req  out  1  data-memory request strobe
- halted  out  1  core stopped
- mem_err  out  1  sticky memory-timeout flag

Behaviour:
- States: RUN, LU_STALL, MEM_WAIT, DRAIN, HALTED. Registered state, stall counter (3b), timeout counter (8b), drain counter (3b), mem_err flop.
- Outputs are Mealy (state + inputs). Defaults: all *_write=1, all flushes=0, mem_req=0.
- Reset (rst_n=0, asynchronous):
  - State -> RUN, counters -> 0, mem_err -> 0.
  - While rst_n=0, outputs are forced: all *_write=0, ifid_flush=idex_flush=memwb_flush=1, mem_req=0, halted=0.
- Hazard detection:
  - lu_hit = idex_memread & idex_rd!=0 & (idex_rd==ifid_rs1 | (ifid_uses_rs2 & idex_rd==ifid_rs2)).
  - x0 never hazards.
- Priority in RUN, highest first: mem wait > redirect > halt > load-use.
- RUN:
  - exmem_memaccess=1:
    - mem_req=1.
    - If mem_ready=0: pc_write=ifid_write=idex_write=exmem_write=0, memwb_flush=1, goto MEM_WAIT, tmo=1.
    - If mem_ready=1: single-cycle access, stay in RUN.
  - ex_redirect=1: ifid_flush=idex_flush=1, stay in RUN. A concurrent lu_hit or id_halt is discarded because it is on the wrong path.
  - id_halt=1: pc_write=ifid_write=0, ifid_flush=1, drain=1, goto DRAIN.
  - lu_hit=1:
    - pc_write=ifid_write=0, idex_flush=1.
    - If LOAD_STALL_CYC=1: stay in RUN. The hazard clears because idex now holds a bubble.
    - If LOAD_STALL_CYC>1: cnt=1, goto LU_STALL.
- LU_STALL:
  - Outputs as lu_hit above.
  - cnt++. When cnt==LOAD_STALL_CYC-1 at the edge, goto RUN.
  - ex_redirect cannot occur here because EX holds a bubble.
- MEM_WAIT:
  - mem_req held 1. All stages frozen as above. tmo++ each cycle.
  - mem_ready=1: release freeze this cycle (defaults), goto RUN.
  - tmo==MEM_TIMEOUT with mem_ready=0: mem_err<=1 (sticky until reset), mem_req=0, goto RUN. The access is dropped; memwb_flush=1 for this cycle.
- DRAIN:
  - pc_write=ifid_write=0, ifid_flush=1. Older instructions keep advancing.
  - MEM_WAIT freezing applies while draining: the drain counter holds, and DRAIN resumes after mem_ready.
  - drain==DRAIN_CYC: goto HALTED.
- HALTED:
  - halted=1. All *_write=0, all flushes=1, mem_req=0.
  - Leaves only on reset.
- Reset mid-stall, mid-wait or mid-drain: immediate return to RUN, no residual counts.

Test Plan:
- LW x5 in EX, ID ADD x6,x5,x1 (rs1=5) -> exactly 1 cycle pc_write=0, ifid_write=0, idex_flush=1, then defaults. Same with rd=x0 -> no stall.
- LOAD_STALL_CYC=2, lu_hit via rs2 with ifid_uses_rs2=1 -> 2 stall cycles. With ifid_uses_rs2=0 -> none.
- ex_redirect=1 same cycle as lu_hit and id_halt -> ifid_flush=idex_flush=1 for 1 cycle, pc_write=1, no stall, halted never asserts.
- exmem_memaccess=1, mem_ready low for 4 cycles -> mem_req=1 and freeze for 4 cycles, release on 5th. Hold low >MEM_TIMEOUT (15) cycles -> mem_err=1 on the 15th wait cycle, return to RUN.
- id_halt=1 in RUN -> halted=1 exactly DRAIN_CYC=3 cycles later. It stays 1; pc_write=0 throughout.
- rst_n pulsed low mid-MEM_WAIT, asynchronous to clk -> outputs forced immediately. After release: RUN, mem_err=0, defaults on first edge.
